// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GRANT_I = 2'b01,
        GRANT_D = 2'b10
    } arb_state_e;

    localparam int STARVE_LIMIT_DEF = 4;
    localparam int STREAK_W         = 4;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Counts consecutive data grants taken while a fetch waits; forces fetch at the limit.
module mem_arb_starve_ctr
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_fetch_req,
    input  logic i_d_grant,
    input  logic i_i_grant,
    output logic o_force_i
);

    localparam logic [STREAK_W-1:0] LIMIT = STREAK_W'(STARVE_LIMIT);

    logic [STREAK_W-1:0] r_streak;

    // Any cycle without a waiting fetch ends the streak.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_streak <= '0;
        end else if (i_i_grant || !i_fetch_req) begin
            r_streak <= '0;
        end else if (i_d_grant && (r_streak != LIMIT)) begin
            r_streak <= r_streak + 1'b1;
        end
    end

    assign o_force_i = i_fetch_req && (r_streak == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises fetch and data requests onto one multi-cycle memory port.
// Data has priority; a starvation counter guarantees fetch progress.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  I_READ,
    input  logic [DATA_WIDTH-1:0] I_ADDRESS,
    output logic [DATA_WIDTH-1:0] I_READDATA,
    output logic                  I_BUSYWAIT,
    input  logic                  D_READ,
    input  logic                  D_WRITE,
    input  logic [DATA_WIDTH-1:0] D_ADDRESS,
    input  logic [DATA_WIDTH-1:0] D_WRITEDATA,
    output logic [DATA_WIDTH-1:0] D_READDATA,
    output logic                  D_BUSYWAIT,
    output logic                  M_READ,
    output logic                  M_WRITE,
    output logic [DATA_WIDTH-1:0] M_ADDRESS,
    output logic [DATA_WIDTH-1:0] M_WRITEDATA,
    input  logic [DATA_WIDTH-1:0] M_READDATA,
    input  logic                  M_BUSYWAIT
);

    arb_state_e            r_state;
    arb_state_e            w_next_state;
    logic                  w_d_req;
    logic                  w_force_i;
    logic                  w_grant_i;
    logic                  w_grant_d;
    logic                  w_done_i;
    logic                  w_done_d;
    logic                  r_m_read;
    logic                  r_m_write;
    logic [DATA_WIDTH-1:0] r_m_address;
    logic [DATA_WIDTH-1:0] r_m_writedata;
    logic [DATA_WIDTH-1:0] r_i_rdata;
    logic [DATA_WIDTH-1:0] r_d_rdata;

    assign w_d_req = D_READ | D_WRITE;

    mem_arb_starve_ctr #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve_ctr (
        .i_clk       (CLK),
        .i_reset     (RESET),
        .i_fetch_req (I_READ),
        .i_d_grant   (w_grant_d),
        .i_i_grant   (w_grant_i),
        .o_force_i   (w_force_i)
    );

    always_ff @(posedge CLK) begin
        if (RESET) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latches.
        w_next_state = r_state;
        w_grant_i    = 1'b0;
        w_grant_d    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_d_req && !w_force_i) begin
                    w_next_state = GRANT_D;
                    w_grant_d    = 1'b1;
                end else if (I_READ) begin
                    w_next_state = GRANT_I;
                    w_grant_i    = 1'b1;
                end
            end
            GRANT_I: if (!M_BUSYWAIT) w_next_state = IDLE;
            GRANT_D: if (!M_BUSYWAIT) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // A transaction only completes outside reset, so BUSYWAIT tracks raw requests then.
    always_comb begin
        w_done_i   = (r_state == GRANT_I) && !M_BUSYWAIT && !RESET;
        w_done_d   = (r_state == GRANT_D) && !M_BUSYWAIT && !RESET;
        I_BUSYWAIT = I_READ  && !w_done_i;
        D_BUSYWAIT = w_d_req && !w_done_d;
        I_READDATA = (r_state == GRANT_I) ? M_READDATA : r_i_rdata;
        D_READDATA = (r_state == GRANT_D) ? M_READDATA : r_d_rdata;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_m_read      <= 1'b0;
            r_m_write     <= 1'b0;
            r_m_address   <= '0;
            r_m_writedata <= '0;
            r_i_rdata     <= '0;
            r_d_rdata     <= '0;
        end else begin
            if (w_grant_d) begin
                r_m_address   <= D_ADDRESS;
                r_m_writedata <= D_WRITEDATA;
                r_m_write     <= D_WRITE;
                r_m_read      <= D_READ & ~D_WRITE;
            end else if (w_grant_i) begin
                r_m_address <= I_ADDRESS;
                r_m_read    <= 1'b1;
                r_m_write   <= 1'b0;
            end else if (w_done_i || w_done_d) begin
                r_m_read  <= 1'b0;
                r_m_write <= 1'b0;
            end
            // Data is kept only if the requester is still waiting for a read.
            if (w_done_i && I_READ)             r_i_rdata <= M_READDATA;
            if (w_done_d && D_READ && r_m_read) r_d_rdata <= M_READDATA;
        end
    end

    assign M_READ      = r_m_read;
    assign M_WRITE     = r_m_write;
    assign M_ADDRESS   = r_m_address;
    assign M_WRITEDATA = r_m_writedata;

endmodule
